// File: rtl/seq_gen_pkg.sv
// Shared types and default parameters for the serial sequence generator.
// Imported by the generator top and its shift-register datapath.
package seq_gen_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP,
      DONE
   } seq_gen_state_t;

   localparam int DEF_PAT_W   = 5;
   localparam int DEF_REP_W   = 4;
   localparam int DEF_GAP_CYC = 1;

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load, MSB-first shift register feeding the serial output.
// Load takes priority over shift; zeros enter at the LSB.
module seq_shift_reg
   import seq_gen_pkg::*;
#(
   parameter int W = DEF_PAT_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         msb
);

   logic [W-1:0] sr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sr <= '0;
      end else if (load) begin
         sr <= din;
      end else if (shift) begin
         sr <= sr << 1;
      end
   end

   assign msb = sr[W-1];

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern generator: sends len bits MSB-first, rep+1 frames,
// with GAP_CYC idle cycles between frames and a done pulse at the end.
module sequence_generator
   import seq_gen_pkg::*;
#(
   parameter int PAT_W   = DEF_PAT_W,
   parameter int REP_W   = DEF_REP_W,
   parameter int GAP_CYC = DEF_GAP_CYC,
   localparam int LEN_W  = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   input  logic [REP_W-1:0] rep,
   input  logic             abort,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             done
);

   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [LEN_W-1:0] PAT_LEN = LEN_W'(PAT_W);
   localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

   seq_gen_state_t   state;
   logic [PAT_W-1:0] pat_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] bit_cnt;
   logic [REP_W-1:0] frame_cnt;
   logic [GAP_W-1:0] gap_cnt;

   logic             go;
   logic             reload;
   logic             sr_load;
   logic             sr_shift;
   logic             sr_msb;
   logic [LEN_W-1:0] len_c;
   logic [LEN_W-1:0] ld_len;
   logic [PAT_W-1:0] ld_pat;
   logic [LEN_W-1:0] ld_sh;
   logic [PAT_W-1:0] ld_aligned;

   assign len_c = (len > PAT_LEN) ? PAT_LEN : len;
   assign go    = (state == IDLE) && start && !abort;

   // Next frame loads straight from the last bit, or at the end of the gap
   assign reload = !abort &&
      (((state == SHIFT) && (bit_cnt == '0) && (frame_cnt != '0) &&
        (GAP_CYC == 0)) ||
       ((state == GAP) && (gap_cnt == '0)));

   assign sr_load  = go || reload;
   assign sr_shift = (state == SHIFT) && !abort;

   // Left-align the frame so bit len-1 sits in the register MSB
   assign ld_pat     = (state == IDLE) ? pattern : pat_q;
   assign ld_len     = (state == IDLE) ? len_c : len_q;
   assign ld_sh      = PAT_LEN - ld_len;
   assign ld_aligned = ld_pat << ld_sh;

   seq_shift_reg #(
      .W (PAT_W)
   ) u_shift (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (sr_load),
      .shift   (sr_shift),
      .din     (ld_aligned),
      .msb     (sr_msb)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         pat_q     <= '0;
         len_q     <= '0;
         bit_cnt   <= '0;
         frame_cnt <= '0;
         gap_cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (go) begin
                  pat_q     <= pattern;
                  len_q     <= len_c;
                  frame_cnt <= rep;
                  if (len_c == '0) begin
                     state <= DONE;
                  end else begin
                     state   <= SHIFT;
                     bit_cnt <= len_c - ONE;
                  end
               end
            end
            SHIFT: begin
               if (abort) begin
                  state <= IDLE;
               end else if (bit_cnt != '0) begin
                  bit_cnt <= bit_cnt - ONE;
               end else if (frame_cnt == '0) begin
                  state <= DONE;
               end else begin
                  frame_cnt <= frame_cnt - 1'b1;
                  if (GAP_CYC > 0) begin
                     state   <= GAP;
                     gap_cnt <= GAP_W'(GAP_CYC - 1);
                  end else begin
                     bit_cnt <= len_q - ONE;
                  end
               end
            end
            GAP: begin
               if (abort) begin
                  state <= IDLE;
               end else if (gap_cnt == '0) begin
                  state   <= SHIFT;
                  bit_cnt <= len_q - ONE;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign dout_valid = (state == SHIFT);
   assign dout       = dout_valid & sr_msb;
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator: stimulus queues expected bits
// and done pulses, a negedge monitor pops and compares them.
module tb_sequence_generator;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [4:0] pattern;
   logic [2:0] len;
   logic [3:0] rep;
   logic       abort;
   logic       dout;
   logic       dout_valid;
   logic       busy;
   logic       done;

   int checks   = 0;
   int failures = 0;

   logic exp_bits[$];
   logic exp_done[$];

   int         done_seen   = 0;
   int         det_matches = 0;
   logic [4:0] det_hist    = '0;
   int         det_cnt     = 0;

   sequence_generator #(
      .PAT_W   (5),
      .REP_W   (4),
      .GAP_CYC (1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .pattern    (pattern),
      .len        (len),
      .rep        (rep),
      .abort      (abort),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor / scoreboard with a 01010 sequence detector on the stream
   always @(negedge clk) begin
      if (reset_n) begin
         if (dout_valid) begin
            check("bit_expected", 32'(exp_bits.size() > 0), 1);
            if (exp_bits.size() > 0) begin
               check("dout_bit", 32'(dout), 32'(exp_bits.pop_front()));
            end
            det_hist = {det_hist[3:0], dout};
            det_cnt++;
            if (det_cnt >= 5 && det_hist == 5'b01010) det_matches++;
         end else if (dout) begin
            check("dout_idle_zero", 32'(dout), 0);
         end
         if (done) begin
            done_seen++;
            check("done_expected", 32'(exp_done.size() > 0), 1);
            if (exp_done.size() > 0) void'(exp_done.pop_front());
            check("bits_left_at_done", exp_bits.size(), 0);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] p, input logic [2:0] l,
                        input logic [3:0] r, input logic [31:0] bits,
                        input int nb, input bit exp_d);
      for (int i = nb - 1; i >= 0; i--) exp_bits.push_back(bits[i]);
      if (exp_d) exp_done.push_back(1'b1);
      pattern = p;
      len     = l;
      rep     = r;
      start   = 1'b1;
      cyc();
      start   = 1'b0;
   endtask

   task automatic wait_done(input int maxc, output int n,
                            output logic [31:0] vt);
      n  = 0;
      vt = '0;
      for (int i = 1; i <= maxc; i++) begin
         if (done) begin
            n = i;
            break;
         end
         vt = {vt[30:0], dout_valid};
         cyc();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic [31:0] vt;
      int          ds;

      reset_n = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      pattern = '0;
      len     = '0;
      rep     = '0;
      #3;
      check("rst_dout", 32'(dout), 0);
      check("rst_valid", 32'(dout_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      cyc();
      reset_n = 1'b1;
      cyc();

      // Single frame 01010
      issue(5'b01010, 3'd5, 4'd0, 32'b01010, 5, 1'b1);
      wait_done(20, n, vt);
      check("t1_done_cycle", n, 6);
      check("t1_valid_trace", vt, 32'b11111);
      check("t1_done_valid", 32'(dout_valid), 0);
      check("t1_done_busy", 32'(busy), 1);
      cyc();
      check("t1_idle_busy", 32'(busy), 0);
      check("t1_detector", det_matches, 1);

      // Three frames of 11 with one-cycle gaps
      issue(5'b00011, 3'd2, 4'd2, 32'b111111, 6, 1'b1);
      wait_done(30, n, vt);
      check("t2_done_cycle", n, 9);
      check("t2_valid_trace", vt, 32'b11011011);
      cyc();

      // Abort on the third bit
      ds = done_seen;
      issue(5'b11001, 3'd5, 4'd0, 32'b110, 3, 1'b0);
      cyc();
      cyc();
      check("t3_third_valid", 32'(dout_valid), 1);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      check("t3_valid_after", 32'(dout_valid), 0);
      check("t3_busy_after", 32'(busy), 0);
      repeat (8) cyc();
      check("t3_no_done", done_seen, ds);

      // Start and pattern changes while busy are ignored
      issue(5'b10011, 3'd5, 4'd1, 32'b1001110011, 10, 1'b1);
      start   = 1'b1;
      pattern = 5'b01100;
      len     = 3'd3;
      rep     = 4'd5;
      cyc();
      cyc();
      start = 1'b0;
      wait_done(30, n, vt);
      check("t4_done_cycle", n, 12 - 2);
      check("t4_valid_trace", vt, 32'b111011111);
      cyc();

      // len=0 gives done with no bits
      issue(5'b11111, 3'd0, 4'd3, 32'b0, 0, 1'b1);
      wait_done(10, n, vt);
      check("t5_len0_cycle", n, 1);
      check("t5_len0_valid", 32'(dout_valid), 0);
      cyc();

      // len=7 clamps to 5 bits
      issue(5'b10110, 3'd7, 4'd0, 32'b10110, 5, 1'b1);
      wait_done(20, n, vt);
      check("t5_len7_cycle", n, 6);
      check("t5_len7_trace", vt, 32'b11111);
      cyc();

      // Asynchronous reset mid-frame, then a fresh start
      issue(5'b11111, 3'd5, 4'd3, 32'b11, 2, 1'b0);
      cyc();
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_rst_dout", 32'(dout), 0);
      check("t6_rst_valid", 32'(dout_valid), 0);
      check("t6_rst_busy", 32'(busy), 0);
      check("t6_rst_done", 32'(done), 0);
      exp_bits.delete();
      exp_done.delete();
      cyc();
      cyc();
      reset_n = 1'b1;
      issue(5'b10101, 3'd5, 4'd0, 32'b10101, 5, 1'b1);
      check("t6_restart_valid", 32'(dout_valid), 1);
      wait_done(20, n, vt);
      check("t6_done_cycle", n, 6);
      cyc();
      cyc();

      check("end_bits_empty", exp_bits.size(), 0);
      check("end_done_empty", exp_done.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 Parameter PAT_W, default 5: maximum pattern length in bits.
REQ-002 Parameter REP_W, default 4: width of the repeat-count input.
REQ-003 Parameter GAP_CYC, default 1: idle cycles between repeated frames; 0 means frames are back-to-back.
REQ-004 clk  in  1  clock; all logic on the rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  request to transmit; sampled only in IDLE.
REQ-007 pattern  in  PAT_W  bits to send; bit len-1 goes first, bit 0 goes last.
REQ-008 len  in  $clog2(PAT_W+1)  number of pattern bits per frame.
REQ-009 rep  in  REP_W  extra frames; total frames = rep+1.
REQ-010 abort  in  1  synchronous cancel.
REQ-011 dout  out  1  serial data bit.
REQ-012 dout_valid  out  1  high when dout carries a pattern bit.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse after the last bit of the last frame.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, SHIFT, GAP, DONE.
REQ-016 In IDLE with start=1 and abort=0, the block SHALL capture pattern, len (clamped to PAT_W if larger) and rep; the next cycle SHALL be SHIFT with dout=pattern[len-1] and dout_valid=1.
REQ-017 If the captured len=0, the IDLE+start transition SHALL go to DONE with no bits sent.
REQ-018 In SHIFT, exactly one bit SHALL be output per cycle, MSB-first, for len consecutive cycles.
REQ-019 After the last bit of a frame with frames remaining, the state SHALL go to GAP when GAP_CYC>0, otherwise straight to SHIFT with the first bit of the next frame in the following cycle.
REQ-020 GAP SHALL last exactly GAP_CYC cycles with dout=0 and dout_valid=0, then return to SHIFT.
REQ-021 After the last bit of the final frame, the state SHALL go to DONE, where done=1, dout_valid=0 and busy=1, for one cycle; the next state SHALL be IDLE.
REQ-022 Outside SHIFT, dout=0 and dout_valid=0 SHALL hold.
REQ-023 start SHALL be ignored in SHIFT, GAP and DONE; changes to pattern, len or rep while busy SHALL have no effect.
REQ-024 When abort=1 in SHIFT, GAP or DONE, the next state SHALL be IDLE, with no done pulse and dout_valid=0 from the next cycle.
REQ-025 When abort=1 and start=1 in the same IDLE cycle, start SHALL be ignored.
REQ-026 The bit counter SHALL count down from len-1 to 0 without wrap; the frame counter SHALL count down from rep to 0, and rep at its maximum (2^REP_W-1) SHALL yield 2^REP_W frames.
REQ-027 All outputs SHALL be registered or decoded only from state registers, with no combinational path from any input to any output.

Reset
REQ-028 Asserting reset_n low SHALL force IDLE immediately, and also mid-frame, with dout=0, dout_valid=0, busy=0 and done=0.
REQ-029 All captured registers and counters SHALL reset to 0.
REQ-030 The first start SHALL be honoured on the first rising edge after reset_n deasserts.

Structure
REQ-031 The state enum type seq_gen_state_t and the default parameter constants SHALL be placed in a shared package, seq_gen_pkg.
REQ-032 A single sub-module, seq_shift_reg, SHALL implement a PAT_W-bit parallel-load, MSB-first shift register with a load/shift enable; the FSM and the counters SHALL be in the top level.

Verification
REQ-033 Bench SHALL cover: pattern=5'b01010, len=5, rep=0, start pulse -> dout 0,1,0,1,0 with dout_valid=1 in cycles 1-5 after start, done=1 in cycle 6, IDLE in cycle 7; a sequence_detector fed from dout SHALL flag a match.
REQ-034 Bench SHALL cover: pattern=5'b00011, len=2, rep=2, GAP_CYC=1 -> frames 1,1 / gap / 1,1 / gap / 1,1, then done; total 9 cycles from start to done.
REQ-035 Bench SHALL cover: abort asserted on the 3rd bit of a len=5 frame -> dout_valid=0 the next cycle, busy=0, and no done pulse.
REQ-036 Bench SHALL cover: start asserted while busy, and pattern changed mid-frame -> output stream unchanged.
REQ-037 Bench SHALL cover: len=0 -> done asserted one cycle after start with dout_valid never set; len=7 with PAT_W=5 -> 5 bits sent.
REQ-038 Bench SHALL cover: reset_n pulsed low mid-frame -> all outputs 0 asynchronously, and a new start after release is accepted normally.
